// File: rtl/spi_master_ctrl.sv
// SPI initiator on the shared system clock: serialises an 11-bit command
// frame onto SS_n/MOSI and, for read-data frames, shifts back a byte from MISO.
module spi_master_ctrl #(
    parameter int unsigned TURN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] din,
    output logic       busy,
    output logic       done,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        TURN,
        RECV,
        FINISH
    } state_t;

    localparam logic [3:0] TURN_LAST =
        (TURN_CYCLES == 0) ? 4'd0 : 4'(TURN_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [10:0] frame_q, frame_d;
    logic        rd_q, rd_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        ss_n_q, ss_n_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        dv_q, dv_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            rd_q    <= 1'b0;
            shift_q <= '0;
            dout_q  <= '0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            rd_q    <= rd_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        rd_d    = rd_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        ss_n_d  = ss_n_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dv_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    frame_d = {cmd[1], cmd[1], cmd[0], din};
                    rd_d    = &cmd;
                    ss_n_d  = 1'b0;
                    mosi_d  = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Frame word is shifted left so bit 10 always holds the next MOSI bit
                mosi_d  = frame_q[10];
                frame_d = {frame_q[9:0], 1'b0};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd10) begin
                    cnt_d = '0;
                    if (!rd_q) begin
                        state_d = FINISH;
                    end else if (TURN_CYCLES == 0) begin
                        state_d = RECV;
                    end else begin
                        state_d = TURN;
                    end
                end
            end
            TURN: begin
                mosi_d = 1'b0;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = '0;
                    state_d = RECV;
                end
            end
            RECV: begin
                mosi_d  = 1'b0;
                shift_d = {shift_q[6:0], MISO};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    cnt_d   = '0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (rd_q) begin
                    dout_d = shift_q;
                    dv_d   = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign SS_n       = ss_n_q;
    assign MOSI       = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (turnaround 2 and 0), each driven
// against a behavioural SPI slave with RAM and a transaction-level reference.
module tb_spi_master_ctrl;

    typedef struct {
        logic [1:0] c;
        logic [7:0] d;
        int         len;
        logic [7:0] dout;
        int         gap;
    } ent_t;

    logic clk;
    int   errors;
    int   checks;
    bit   fin [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int g,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", nm, g, act, exp);
        end
    endtask

    function automatic logic [7:0] ram_init(input int a);
        return 8'(a * 7 + 3);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int TC = (g == 0) ? 2 : 0;

        logic       rst, start, MISO;
        logic       busy, done, dout_valid, SS_n, MOSI;
        logic [1:0] cmd;
        logic [7:0] din, dout;

        spi_master_ctrl #(.TURN_CYCLES(TC)) dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start),
            .cmd       (cmd),
            .din       (din),
            .busy      (busy),
            .done      (done),
            .dout      (dout),
            .dout_valid(dout_valid),
            .SS_n      (SS_n),
            .MOSI      (MOSI),
            .MISO      (MISO)
        );

        ent_t       q[$];
        logic [7:0] sram [256];
        logic [7:0] sra;
        logic [7:0] rram [256];
        logic [7:0] rra;
        logic [7:0] rlast;

        initial begin
            for (int i = 0; i < 256; i++) begin
                sram[i] = ram_init(i);
                rram[i] = ram_init(i);
            end
            sra   = '0;
            rra   = '0;
            rlast = '0;
        end

        function automatic void expect_frame(input logic [1:0] c,
                                             input logic [7:0] d,
                                             input int gap);
            ent_t e;
            case (c)
                2'd0: rra = d;
                2'd1: rram[rra] = d;
                2'd2: rra = d;
                default: rlast = rram[rra];
            endcase
            e.c    = c;
            e.d    = d;
            e.len  = (c == 2'd3) ? 20 + TC : 12;
            e.dout = rlast;
            e.gap  = gap;
            q.push_back(e);
        endfunction

        task automatic wait_idle();
            int n;
            n = 0;
            while (busy && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (busy) chk("busy_timeout", g, 1, 0);
        endtask

        task automatic scramble();
            cmd = 2'($urandom);
            din = 8'($urandom);
        endtask

        task automatic issue(input logic [1:0] c, input logic [7:0] d);
            wait_idle();
            start = 1'b1;
            cmd   = c;
            din   = d;
            expect_frame(c, d, -1);
            @(posedge clk);
            #1;
            start = 1'b0;
            scramble();
        endtask

        // Second request is presented while the first frame is busy and
        // start is never dropped, so it launches on the edge after FINISH.
        task automatic issue2(input logic [1:0] c1, input logic [7:0] d1,
                              input logic [1:0] c2, input logic [7:0] d2);
            wait_idle();
            start = 1'b1;
            cmd   = c1;
            din   = d1;
            expect_frame(c1, d1, -1);
            @(posedge clk);
            #1;
            cmd = c2;
            din = d2;
            expect_frame(c2, d2, 1);
            wait_idle();
            @(posedge clk);
            #1;
            start = 1'b0;
            scramble();
        endtask

        task automatic reset_checks(input string nm);
            chk({nm, "_ss_n"}, g, 32'(SS_n), 1);
            chk({nm, "_mosi"}, g, 32'(MOSI), 0);
            chk({nm, "_busy"}, g, 32'(busy), 0);
            chk({nm, "_done"}, g, 32'({done, dout_valid}), 0);
            chk({nm, "_dout"}, g, 32'(dout), 0);
        endtask

        initial begin : mon
            int         k;
            int         hi;
            bit         inf;
            bit         rdf;
            logic [10:0] bits;
            logic [7:0]  reply;
            ent_t        e;
            k     = 0;
            hi    = 0;
            inf   = 1'b0;
            rdf   = 1'b0;
            bits  = '0;
            reply = '0;
            MISO  = 1'b0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    inf = 1'b0;
                    hi  = 0;
                end else begin
                    if (inf) begin
                        k++;
                    end else if (!SS_n) begin
                        inf  = 1'b1;
                        k    = 0;
                        bits = '0;
                        rdf  = 1'b0;
                        if (q.size() == 0) chk("unexpected_frame", g, 1, 0);
                        else if (q[0].gap >= 0) chk("gap", g, hi, q[0].gap);
                    end
                    if (inf && !SS_n) begin
                        if (k >= 1 && k <= 11) bits = {bits[9:0], MOSI};
                        else chk("mosi_quiet", g, 32'(MOSI), 0);
                        if (k == 11) begin
                            case (bits[9:8])
                                2'd0: sra = bits[7:0];
                                2'd1: sram[sra] = bits[7:0];
                                2'd2: sra = bits[7:0];
                                default: begin
                                    rdf   = 1'b1;
                                    reply = sram[sra];
                                end
                            endcase
                        end
                        if (rdf && k >= 11 + TC && k <= 18 + TC)
                            MISO = reply[7 - (k - 11 - TC)];
                        else
                            MISO = 1'($urandom);
                        chk("done_early", g, 32'({done, dout_valid}), 0);
                    end else if (inf) begin
                        inf  = 1'b0;
                        hi   = 1;
                        MISO = 1'($urandom);
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            chk("frame_bits", g, 32'(bits),
                                32'({e.c[1], e.c[1], e.c[0], e.d}));
                            chk("ss_low_len", g, k, e.len);
                            chk("done", g, 32'(done), 1);
                            chk("dout_valid", g, 32'(dout_valid),
                                32'(e.c == 2'd3));
                            chk("dout", g, 32'(dout), 32'(e.dout));
                        end
                    end else begin
                        hi++;
                        chk("idle_outputs", g,
                            32'({done, dout_valid, MOSI, busy}), 0);
                    end
                end
            end
        end

        initial begin : drv
            logic [1:0] c1, c2;
            logic [7:0] d1, d2;
            int         n;
            rst   = 1'b1;
            start = 1'b0;
            cmd   = '0;
            din   = '0;
            repeat (2) @(posedge clk);
            #1;
            reset_checks("reset");
            rst = 1'b0;
            @(posedge clk);
            #1;

            issue(2'd0, 8'hA5);
            issue2(2'd1, 8'h3C, 2'd2, 8'h0F);
            issue(2'd0, 8'h40);
            issue(2'd1, (g == 0) ? 8'hC3 : 8'h81);
            issue(2'd2, 8'h40);
            issue(2'd3, 8'h00);

            // Request presented during a frame must be dropped
            issue(2'd0, 8'h12);
            repeat (4) @(posedge clk);
            #1;
            start = 1'b1;
            cmd   = 2'd3;
            din   = 8'hFF;
            @(posedge clk);
            #1;
            start = 1'b0;
            wait_idle();
            repeat (3) @(posedge clk);
            #1;

            // Abort a frame between E6 and E7
            wait_idle();
            start = 1'b1;
            cmd   = 2'd0;
            din   = 8'h99;
            q.push_back('{c: 2'd0, d: 8'h99, len: 12, dout: rlast, gap: -1});
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (6) @(posedge clk);
            #2;
            rst = 1'b1;
            #1;
            q.delete();
            rlast = '0;
            reset_checks("midreset");
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            issue(2'd0, 8'h55);

            issue(2'd0, 8'h10);
            issue(2'd1, 8'hAA);
            issue(2'd2, 8'h10);
            issue(2'd3, 8'h5E);

            repeat (40) begin
                c1 = 2'($urandom);
                d1 = 8'($urandom);
                c2 = 2'($urandom);
                d2 = 8'($urandom);
                if ($urandom_range(0, 3) == 0) issue2(c1, d1, c2, d2);
                else issue(c1, d1);
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end

            n = 0;
            while (q.size() != 0 && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("drain", g, q.size(), 0);
            fin[g] = 1'b1;
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        fin[0] = 1'b0;
        fin[1] = 1'b0;
        for (int n = 0; n < 40000 && !(fin[0] && fin[1]); n++)
            @(posedge clk);
        if (!(fin[0] && fin[1])) begin
            checks++;
            errors++;
            $display("FAIL timeout: drivers finished %0d/%0d, required 1/1",
                     fin[0], fin[1]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
